// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream sink checker: FSM state encoding,
// keep-to-byte-mask expansion, popcount and the backpressure LFSR tap set.
package axis_pkg;

  localparam int unsigned MaxKeepWd = 64;
  localparam int unsigned MaxDataWd = 8 * MaxKeepWd;

  // Fibonacci taps 16,14,13,11 as a mask over state bits [15:0].
  localparam logic [15:0] LfsrTaps = 16'hB400;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRecv   = 2'd1,
    StReport = 2'd2
  } axis_state_e;

  function automatic logic [MaxDataWd-1:0] keep_mask(input logic [MaxKeepWd-1:0] keep);
    logic [MaxDataWd-1:0] m;
    m = '0;
    for (int i = 0; i < MaxKeepWd; i++) begin
      m[8*i +: 8] = {8{keep[i]}};
    end
    return m;
  endfunction

  function automatic int unsigned popcount(input logic [MaxKeepWd-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MaxKeepWd; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_lfsr16.sv
// 16-bit Fibonacci LFSR used to throttle s_tready; shifts left, feedback into bit 0.
module axis_lfsr16
  import axis_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[14:0], ^(state & LfsrTaps)};
    end
  end

endmodule

// File: rtl/axi_stream_sink_checker.sv
// AXI-Stream sink that counts beats/bytes, checksums masked data and checks length and keep.
// Define AXIS_SINK_BACKPRESSURE_EN to throttle s_tready with a 16-bit LFSR.
module axi_stream_sink_checker
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned EXP_BEATS    = 10,
`ifdef AXIS_SINK_BACKPRESSURE_EN
  parameter int unsigned CNT_WD       = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
`else
  parameter int unsigned CNT_WD       = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  input  logic [DATA_BYTE_WD-1:0] s_tkeep,
  input  logic [DATA_WD-1:0]      s_tdata,
  output logic                    pkt_done,
  output logic [CNT_WD-1:0]       pkt_beats,
  output logic [CNT_WD-1:0]       pkt_bytes,
  output logic [DATA_WD-1:0]      pkt_sum,
  output logic                    pkt_len_err,
  output logic                    pkt_keep_err,
  output logic [CNT_WD-1:0]       pkt_count,
  output logic                    err_sticky,
  output logic                    busy
);

  axis_state_e             state_q;
  logic                    rdy_en_q;
  logic [CNT_WD-1:0]       beat_q, bytes_q;
  logic [DATA_WD-1:0]      sum_q;
  logic                    keep_err_q;
  logic [CNT_WD-1:0]       pkt_beats_q, pkt_bytes_q, pkt_count_q;
  logic [DATA_WD-1:0]      pkt_sum_q;
  logic                    pkt_len_err_q, pkt_keep_err_q, err_sticky_q;

  logic                    bp_ready;
  logic                    xfer;
  logic [MaxKeepWd-1:0]    keep_ext;
  logic [DATA_WD-1:0]      data_mask;
  logic [CNT_WD-1:0]       beat_inc, byte_inc;
  logic [CNT_WD:0]         byte_sum;
  logic [DATA_WD-1:0]      sum_inc;
  logic                    keep_bad;

`ifdef AXIS_SINK_BACKPRESSURE_EN
  logic [15:0] lfsr;

  axis_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .state (lfsr)
  );

  assign bp_ready = lfsr[0] | lfsr[1];
`else
  assign bp_ready = 1'b1;
`endif

  always_comb begin
    keep_ext                   = '0;
    keep_ext[DATA_BYTE_WD-1:0] = s_tkeep;
  end

  // rdy_en_q keeps s_tready low while in reset and for the first cycle after it.
  assign s_tready  = rdy_en_q & (state_q != StReport) & bp_ready;
  assign xfer      = s_tvalid & s_tready;
  assign data_mask = DATA_WD'(keep_mask(keep_ext));
  assign beat_inc  = (beat_q == '1) ? beat_q : beat_q + 1'b1;
  assign byte_sum  = {1'b0, bytes_q} + (CNT_WD+1)'(popcount(keep_ext));
  assign byte_inc  = byte_sum[CNT_WD] ? '1 : byte_sum[CNT_WD-1:0];
  assign sum_inc   = sum_q + (s_tdata & data_mask);
  assign keep_bad  = s_tlast ? (s_tkeep == '0) : (s_tkeep != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      rdy_en_q       <= 1'b0;
      beat_q         <= '0;
      bytes_q        <= '0;
      sum_q          <= '0;
      keep_err_q     <= 1'b0;
      pkt_beats_q    <= '0;
      pkt_bytes_q    <= '0;
      pkt_sum_q      <= '0;
      pkt_len_err_q  <= 1'b0;
      pkt_keep_err_q <= 1'b0;
      pkt_count_q    <= '0;
      err_sticky_q   <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      unique case (state_q)
        StIdle, StRecv: begin
          if (xfer) begin
            beat_q     <= beat_inc;
            bytes_q    <= byte_inc;
            sum_q      <= sum_inc;
            keep_err_q <= keep_err_q | keep_bad;
            if (s_tlast) begin
              state_q        <= StReport;
              pkt_beats_q    <= beat_inc;
              pkt_bytes_q    <= byte_inc;
              pkt_sum_q      <= sum_inc;
              pkt_len_err_q  <= (beat_inc != CNT_WD'(EXP_BEATS));
              pkt_keep_err_q <= keep_err_q | keep_bad;
            end else begin
              state_q <= StRecv;
            end
          end
        end
        StReport: begin
          state_q      <= StIdle;
          beat_q       <= '0;
          bytes_q      <= '0;
          sum_q        <= '0;
          keep_err_q   <= 1'b0;
          pkt_count_q  <= pkt_count_q + 1'b1;
          err_sticky_q <= err_sticky_q | pkt_len_err_q | pkt_keep_err_q;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pkt_done     = (state_q == StReport);
  assign busy         = (state_q != StIdle);
  assign pkt_beats    = pkt_beats_q;
  assign pkt_bytes    = pkt_bytes_q;
  assign pkt_sum      = pkt_sum_q;
  assign pkt_len_err  = pkt_len_err_q;
  assign pkt_keep_err = pkt_keep_err_q;
  assign pkt_count    = pkt_count_q;
  assign err_sticky   = err_sticky_q;

endmodule

// File: tb/tb_axi_stream_sink_checker.sv
// Self-checking bench for axi_stream_sink_checker: table-driven packets, hand sequences for
// REPORT hold and mid-packet reset, then random packets checked against a packet-level model.
module tb_axi_stream_sink_checker;

  logic        clk;
  logic        rst_n;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [3:0]  s_tkeep;
  logic [31:0] s_tdata;
  logic        pkt_done;
  logic [15:0] pkt_beats;
  logic [15:0] pkt_bytes;
  logic [31:0] pkt_sum;
  logic        pkt_len_err;
  logic        pkt_keep_err;
  logic [15:0] pkt_count;
  logic        err_sticky;
  logic        busy;

  axi_stream_sink_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .s_tkeep      (s_tkeep),
    .s_tdata      (s_tdata),
    .pkt_done     (pkt_done),
    .pkt_beats    (pkt_beats),
    .pkt_bytes    (pkt_bytes),
    .pkt_sum      (pkt_sum),
    .pkt_len_err  (pkt_len_err),
    .pkt_keep_err (pkt_keep_err),
    .pkt_count    (pkt_count),
    .err_sticky   (err_sticky),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int exp_cnt = 0;
  logic exp_sticky = 1'b0;

  logic [31:0] tx_data[$];
  logic [3:0]  tx_keep[$];

  always @(negedge clk) if (pkt_done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives tx_* as a packet, one beat per accepted transfer; returns #1 after the last transfer.
  task automatic send_pkt(input bit with_last, input bit gaps);
    bit rdy;
    int waited;
    for (int i = 0; i < tx_data.size(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        s_tvalid = 1'b0;
        s_tdata  = 'x;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = tx_data[i];
      s_tkeep  = tx_keep[i];
      s_tlast  = with_last && (i == tx_data.size() - 1);
      waited   = 0;
      forever begin
        @(negedge clk);
        rdy = s_tready;
        @(posedge clk);
        #1;
        if (rdy) break;
        waited++;
        if (waited > 50) begin
          n_chk++;
          n_fail++;
          $display("FAIL tready_timeout: got 0 expected 1 within 50 cycles at %0t", $time);
          break;
        end
      end
    end
  endtask

  // Called in the REPORT cycle; steps one clock and checks the post-report status.
  task automatic check_report(input logic [15:0] e_beats, input logic [15:0] e_bytes,
                              input logic [31:0] e_sum, input logic e_len, input logic e_keep);
    chk("pkt_done", pkt_done, 1);
    chk("tready_in_report", s_tready, 0);
    chk("busy_report", busy, 1);
    chk("pkt_beats", pkt_beats, e_beats);
    chk("pkt_bytes", pkt_bytes, e_bytes);
    chk("pkt_sum", pkt_sum, e_sum);
    chk("pkt_len_err", pkt_len_err, e_len);
    chk("pkt_keep_err", pkt_keep_err, e_keep);
    exp_cnt++;
    exp_done++;
    exp_sticky = exp_sticky | e_len | e_keep;
    @(posedge clk);
    #1;
    chk("pkt_done_low", pkt_done, 0);
    chk("pkt_count", pkt_count, 16'(exp_cnt));
    chk("err_sticky", err_sticky, exp_sticky);
    chk("pkt_beats_held", pkt_beats, e_beats);
    chk("done_pulses", done_cnt, exp_done);
  endtask

  // Packet-level reference: results follow from the beat list alone.
  task automatic model_check();
    logic [15:0] b;
    logic [31:0] s;
    logic [31:0] m;
    logic ke;
    int n;
    n  = tx_data.size();
    b  = 0;
    s  = 0;
    ke = 1'b0;
    for (int i = 0; i < n; i++) begin
      b += 16'($countones(tx_keep[i]));
      for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{tx_keep[i][k]}};
      s += tx_data[i] & m;
      if (i == n - 1) ke |= (tx_keep[i] == 4'h0);
      else            ke |= (tx_keep[i] != 4'hF);
    end
    check_report(16'(n), b, s, n != 10, ke);
  endtask

  typedef struct {
    int          n;
    logic [3:0]  last_keep;
    int          bad_idx;
    logic [3:0]  bad_keep;
    logic [15:0] e_beats;
    logic [15:0] e_bytes;
    logic [31:0] e_sum;
    logic        e_len;
    logic        e_keep;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{10, 4'hE, -1, 4'h0, 16'd10, 16'd39, 32'd45, 1'b0, 1'b0};
    tbl[1] = '{7,  4'hF, -1, 4'h0, 16'd7,  16'd28, 32'd28, 1'b1, 1'b0};
    tbl[2] = '{10, 4'hF, 2,  4'h3, 16'd10, 16'd38, 32'd55, 1'b0, 1'b1};
    tbl[3] = '{10, 4'h0, -1, 4'h0, 16'd10, 16'd36, 32'd45, 1'b0, 1'b1};
    tbl[4] = '{1,  4'hF, -1, 4'h0, 16'd1,  16'd4,  32'd1,  1'b1, 1'b0};
    tbl[5] = '{10, 4'hF, -1, 4'h0, 16'd10, 16'd40, 32'd55, 1'b0, 1'b0};

    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tkeep  = 4'h0;
    s_tdata  = '0;
    #1;
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_pkt_beats", pkt_beats, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifndef AXIS_SINK_BACKPRESSURE_EN
    chk("tready_after_reset", s_tready, 1);
`endif

    // Table packets, back to back with tvalid held through each REPORT.
    foreach (tbl[t]) begin
      tx_data.delete();
      tx_keep.delete();
      for (int i = 0; i < tbl[t].n; i++) begin
        tx_data.push_back(32'(i + 1));
        if (i == tbl[t].n - 1)        tx_keep.push_back(tbl[t].last_keep);
        else if (i == tbl[t].bad_idx) tx_keep.push_back(tbl[t].bad_keep);
        else                          tx_keep.push_back(4'hF);
      end
      send_pkt(1'b1, 1'b0);
      check_report(tbl[t].e_beats, tbl[t].e_bytes, tbl[t].e_sum, tbl[t].e_len, tbl[t].e_keep);
    end

    // Beat offered during REPORT must be held off, then accepted as its own packet.
    tx_data = '{32'd7};
    tx_keep = '{4'hF};
    send_pkt(1'b1, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'hA5A5_0001;
    s_tkeep  = 4'hF;
    s_tlast  = 1'b1;
    check_report(16'd1, 16'd4, 32'd7, 1'b1, 1'b0);
    chk("idle_tready", s_tready, 1);
    @(posedge clk);
    #1;
    check_report(16'd1, 16'd4, 32'hA5A5_0001, 1'b1, 1'b0);
    s_tvalid = 1'b0;

    // Reset after 4 beats drops the partial packet with no report.
    tx_data = '{32'd1, 32'd2, 32'd3, 32'd4};
    tx_keep = '{4'hF, 4'hF, 4'hF, 4'hF};
    send_pkt(1'b0, 1'b0);
    chk("busy_mid_pkt", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pkt_done", pkt_done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tready", s_tready, 0);
    chk("mid_rst_pkt_count", pkt_count, 0);
    chk("mid_rst_err_sticky", err_sticky, 0);
    chk("mid_rst_pkt_sum", pkt_sum, 0);
    chk("mid_rst_pkt_keep_err", pkt_keep_err, 0);
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt    = 0;
    exp_sticky = 1'b0;
    @(posedge clk);
    #1;
    tx_data.delete();
    tx_keep.delete();
    for (int i = 0; i < 10; i++) begin
      tx_data.push_back(32'(i + 1));
      tx_keep.push_back(4'hF);
    end
    send_pkt(1'b1, 1'b0);
    check_report(16'd10, 16'd40, 32'd55, 1'b0, 1'b0);

    // Random packets against the packet-level model.
    for (int p = 0; p < 20; p++) begin
      int n;
      n = $urandom_range(1, 12);
      tx_data.delete();
      tx_keep.delete();
      for (int i = 0; i < n; i++) begin
        tx_data.push_back($urandom);
        if (i == n - 1)                    tx_keep.push_back(4'($urandom_range(0, 15)));
        else if ($urandom_range(0, 7) == 0) tx_keep.push_back(4'($urandom_range(0, 15)));
        else                               tx_keep.push_back(4'hF);
      end
      send_pkt(1'b1, p[0]);
      model_check();
    end
    s_tvalid = 1'b0;
    chk("final_pkt_count", pkt_count, 16'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1);
  end

endmodule
